// File: rtl/pipe_adder.sv
// pipe_adder: N-bit add/subtract split into STAGES carry slices, valid/ready.
// Optional PIPE_ADDER_SAT_EN clamps s to the signed limit on overflow.
module pipe_adder #(
  parameter int N      = 22,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         co,
  output logic         ovf
);

  localparam int W = (N + STAGES - 1) / STAGES;

  logic adv;

  // whole pipe moves together; any stalled result freezes every slice
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W;
    localparam int WK = (k == STAGES - 1) ? N - LO : W;
    localparam int HW = N - LO;

    logic [HW-1:0]    ai;
    logic [HW-1:0]    bi;
    logic             cin;
    logic             vin;
    logic [WK:0]      r;
    logic [LO+WK-1:0] s_d;

    // one slice of the carry chain
    assign r = {1'b0, ai[WK-1:0]}
             + {1'b0, bi[WK-1:0]}
             + {{WK{1'b0}}, cin};

    if (k == 0) begin : g_in
      assign ai  = a;
      assign bi  = b ^ {N{sub}};
      assign cin = sub | ci;
      assign vin = in_valid;
      assign s_d = r[WK-1:0];
    end else begin : g_in
      assign ai  = g_st[k-1].g_fw.a_q;
      assign bi  = g_st[k-1].g_fw.b_q;
      assign cin = g_st[k-1].g_fw.c_q;
      assign vin = g_st[k-1].g_fw.v_q;
      assign s_d = {r[WK-1:0], g_st[k-1].g_fw.s_q};
    end

    if (k < STAGES - 1) begin : g_fw
      logic [HW-WK-1:0] a_q;
      logic [HW-WK-1:0] b_q;
      logic [LO+WK-1:0] s_q;
      logic             c_q;
      logic             v_q;

      // slice register: valid always advances, data only with a live beat
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          v_q <= vin;
          if (vin) begin
            a_q <= ai[HW-1:WK];
            b_q <= bi[HW-1:WK];
            s_q <= s_d;
            c_q <= r[WK];
          end
        end
      end
    end else begin : g_last
      logic         ov_d;
      logic [N-1:0] s_fin;

      assign ov_d = (ai[WK-1] == bi[WK-1])
                 && (r[WK-1] != ai[WK-1]);

`ifdef PIPE_ADDER_SAT_EN
      // both operands negative -> clamp low, else clamp high
      assign s_fin = !ov_d    ? s_d
                   : ai[WK-1] ? {1'b1, {(N-1){1'b0}}}
                   :            {1'b0, {(N-1){1'b1}}};
`else
      assign s_fin = s_d;
`endif

      // output register holds result, carry and overflow together
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          s         <= '0;
          co        <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= vin;
          if (vin) begin
            s   <= s_fin;
            co  <= r[WK];
            ovf <= ov_d;
          end
        end
      end
    end
  end

endmodule
